// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - result-bus bundle between functional units, cdb_arbiter and the complete stage
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int PREG_W  = 6,
    parameter int ROB_W   = 5,
    parameter int XLEN    = 32
) ();
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*PREG_W-1:0] req_tag;
    logic [NUM_REQ*ROB_W-1:0]  req_rob_idx;
    logic [NUM_REQ*XLEN-1:0]   req_result;
    logic [NUM_REQ*XLEN-1:0]   req_rs2;
    logic [NUM_REQ-1:0]        req_take_branch;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      out_valid;
    logic [PREG_W-1:0]         out_tag;
    logic [ROB_W-1:0]          out_rob_idx;
    logic [XLEN-1:0]           out_result;
    logic [XLEN-1:0]           out_rs2;
    logic                      out_take_branch;
    logic [SRC_W-1:0]          out_src;

    modport master (
        output req_valid, req_tag, req_rob_idx, req_result, req_rs2, req_take_branch,
        input  req_ready,
        input  out_valid, out_tag, out_rob_idx, out_result, out_rs2, out_take_branch, out_src
    );

    modport slave (
        input  req_valid, req_tag, req_rob_idx, req_result, req_rs2, req_take_branch,
        output req_ready,
        output out_valid, out_tag, out_rob_idx, out_result, out_rs2, out_take_branch, out_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common-data-bus arbiter, round-robin by default, fixed priority with CDB_ARB_FIXED_PRIO_EN
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PREG_W  = 6,
    parameter int ROB_W   = 5,
    parameter int XLEN    = 32
) (
    input logic         clock,
    input logic         reset,
    input logic         squash,
    cdb_arbiter_if.slave bus
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] slot_valid;
    logic [PREG_W-1:0]  slot_tag         [NUM_REQ];
    logic [ROB_W-1:0]   slot_rob_idx     [NUM_REQ];
    logic [XLEN-1:0]    slot_result      [NUM_REQ];
    logic [XLEN-1:0]    slot_rs2         [NUM_REQ];
    logic [NUM_REQ-1:0] slot_take_branch;

    logic [NUM_REQ-1:0] grant_vec;
    logic [NUM_REQ-1:0] accept;
    logic               grant_any;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   search_base;

`ifdef CDB_ARB_FIXED_PRIO_EN
    assign search_base = '0;
`else
    logic [SRC_W-1:0] ptr;

    assign search_base = ptr;

    // Round-robin pointer moves past the winner; squash and idle cycles leave it alone
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (!squash && grant_any) begin
            ptr <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    // Pick the first occupied slot starting at search_base, wrapping around
    always_comb begin
        int idx;
        idx       = 0;
        grant_vec = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(search_base) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && slot_valid[idx]) begin
                grant_any      = 1'b1;
                grant_idx      = SRC_W'(idx);
                grant_vec[idx] = 1'b1;
            end
        end
    end

    // A slot can take a new result when empty or when it drains this cycle
    assign bus.req_ready = (reset || squash) ? '0 : (~slot_valid | grant_vec);
    assign accept        = bus.req_valid & bus.req_ready;

    // Occupancy: reload wins over the grant that frees the slot
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            slot_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    slot_valid[i] <= 1'b1;
                end else if (grant_vec[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Payload capture; accept is already gated off by reset and squash
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                slot_tag[i]         <= bus.req_tag[i*PREG_W +: PREG_W];
                slot_rob_idx[i]     <= bus.req_rob_idx[i*ROB_W +: ROB_W];
                slot_result[i]      <= bus.req_result[i*XLEN +: XLEN];
                slot_rs2[i]         <= bus.req_rs2[i*XLEN +: XLEN];
                slot_take_branch[i] <= bus.req_take_branch[i];
            end
        end
    end

    // Completion register: one granted result per cycle, no backpressure
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.out_valid       <= 1'b0;
            bus.out_tag         <= '0;
            bus.out_rob_idx     <= '0;
            bus.out_result      <= '0;
            bus.out_rs2         <= '0;
            bus.out_take_branch <= 1'b0;
            bus.out_src         <= '0;
        end else begin
            bus.out_valid <= grant_any && !squash;
            if (grant_any) begin
                bus.out_tag         <= slot_tag[grant_idx];
                bus.out_rob_idx     <= slot_rob_idx[grant_idx];
                bus.out_result      <= slot_result[grant_idx];
                bus.out_rs2         <= slot_rs2[grant_idx];
                bus.out_take_branch <= slot_take_branch[grant_idx];
                bus.out_src         <= grant_idx;
            end
        end
    end
endmodule
